// File: rtl/collision_event_arbiter_if.sv
// Collision event arbiter bus: hit pulses and ack in, offer/status out.
// Width parameters must match those of the collision_event_arbiter instance.
interface collision_event_arbiter_if #(
    parameter int NUM_EVENTS = 7,
    parameter int ID_WIDTH   = 3
);
    logic [NUM_EVENTS-1:0] hit_pulse;
    logic                  event_ack;
    logic                  event_valid;
    logic [ID_WIDTH-1:0]   event_id;
    logic [NUM_EVENTS-1:0] pending;
    logic [7:0]            drop_count;
    logic                  timeout_err;

    modport master (
        output hit_pulse, event_ack,
        input  event_valid, event_id, pending, drop_count, timeout_err
    );

    modport slave (
        input  hit_pulse, event_ack,
        output event_valid, event_id, pending, drop_count, timeout_err
    );
endinterface

// File: rtl/collision_event_arbiter.sv
// Queues collision events, offers one at a time with ack/timeout handshake.
// Optional COLLISION_ARB_ROUND_ROBIN_EN selects round-robin instead of lowest-index-first.
module collision_event_arbiter #(
    parameter int NUM_EVENTS  = 7,
    parameter int ID_WIDTH    = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    collision_event_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OFFER, GAP} state_t;

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int CW = $clog2(NUM_EVENTS + 1);
    localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT - 1);

    state_t                state;
    logic                  valid_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [NUM_EVENTS-1:0] pending_q;
    logic [7:0]            drop_q;
    logic                  timeout_q;
    logic [TW-1:0]         timer;

    logic [ID_WIDTH-1:0]   winner;
    logic                  offer_end;
    logic [NUM_EVENTS-1:0] offered_mask;
    logic [NUM_EVENTS-1:0] clr;
    logic [NUM_EVENTS-1:0] keep;
    logic [NUM_EVENTS-1:0] drops;
    logic [NUM_EVENTS-1:0] pending_next;
    logic [CW-1:0]         ndrops;
    logic [8:0]            drop_sum;
    logic [7:0]            drop_next;

`ifdef COLLISION_ARB_ROUND_ROBIN_EN
    logic [ID_WIDTH-1:0] rr_ptr;
    int unsigned         best_d;
    int unsigned         dist;

    // Distance from (ptr+1) upward, modulo NUM_EVENTS; the smallest distance wins.
    always_comb begin
        winner = '0;
        best_d = NUM_EVENTS;
        dist   = 0;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            dist = (i + 2 * NUM_EVENTS - 1 - 32'(rr_ptr)) % NUM_EVENTS;
            if (pending_q[i] && dist < best_d) begin
                best_d = dist;
                winner = ID_WIDTH'(i);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int unsigned i = NUM_EVENTS; i > 0; i--) begin
            if (pending_q[i-1]) winner = ID_WIDTH'(i - 1);
        end
    end
`endif

    always_comb begin
        offer_end    = (state == OFFER) && (bus.event_ack || timer == LAST);
        offered_mask = NUM_EVENTS'(1) << id_q;
        clr          = offer_end ? offered_mask : '0;
        keep         = '1;
        if (startOfFrame) keep = (state == OFFER) ? offered_mask : '0;
        drops        = bus.hit_pulse & pending_q & ~clr;
        // Sets are ORed in last so a same-cycle hit survives ack, timeout and frame start.
        pending_next = (pending_q & keep & ~clr) | bus.hit_pulse;
        ndrops       = '0;
        for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
            ndrops = ndrops + CW'(drops[k]);
        end
        drop_sum  = (startOfFrame ? 9'd0 : {1'b0, drop_q}) + 9'(ndrops);
        drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            pending_q <= '0;
            drop_q    <= '0;
            timeout_q <= 1'b0;
            timer     <= '0;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
            rr_ptr    <= '0;
`endif
        end else begin
            pending_q <= pending_next;
            drop_q    <= drop_next;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending_q) begin
                        id_q    <= winner;
                        valid_q <= 1'b1;
                        timer   <= '0;
                        state   <= OFFER;
                    end
                end
                OFFER: begin
                    if (offer_end) begin
                        valid_q   <= 1'b0;
                        timeout_q <= ~bus.event_ack;
                        state     <= GAP;
`ifdef COLLISION_ARB_ROUND_ROBIN_EN
                        rr_ptr    <= id_q;
`endif
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.event_valid = valid_q;
    assign bus.event_id    = id_q;
    assign bus.pending     = pending_q;
    assign bus.drop_count  = drop_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: doc/collision_event_arbiter.md
COLLISION_EVENT_ARBITER -- requirements
Module: collision_event_arbiter

Interface
REQ-001 Parameter NUM_EVENTS, default 7: number of collision event sources (one per collision type).
REQ-002 Parameter ID_WIDTH, default 3: width of event_id, >= clog2(NUM_EVENTS).
REQ-003 Parameter ACK_TIMEOUT, default 15: clock cycles an offer is held without ack before it is abandoned.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 resetN  in  1  synchronous, active-high reset; 1 = reset, sampled on the rising clk edge.
REQ-006 startOfFrame  in  1  one-cycle pulse at frame start.
REQ-007 hit_pulse  in  NUM_EVENTS  one-cycle collision pulses from hit detection; bit k = collision type k.
REQ-008 event_ack  in  1  consumer (score/lives logic) accepts the offered event.
REQ-009 event_valid  out  1  an event is offered.
REQ-010 event_id  out  ID_WIDTH  index of the offered event, stable while event_valid=1.
REQ-011 pending  out  NUM_EVENTS  registered set of queued events.
REQ-012 drop_count  out  8  events lost this frame, saturating.
REQ-013 timeout_err  out  1  one-cycle pulse when an offer is abandoned.

Function
REQ-014 pending[k] SHALL be set on the edge after hit_pulse[k]=1; set has priority over every clear in the same cycle.
REQ-015 hit_pulse[k]=1 while pending[k]=1 and not cleared that cycle SHALL increment drop_count by 1, saturating at 255; simultaneous drops on several bits SHALL each count, with the sum still saturating at 255.
REQ-016 FSM states: IDLE, OFFER, GAP.
REQ-017 IDLE: if pending != 0, register winner into event_id, assert event_valid, and go to OFFER on the same edge; otherwise remain.
REQ-018 Latency: hit_pulse at cycle N with FSM in IDLE and no other pending SHALL give event_valid=1 at cycle N+2.
REQ-019 OFFER: event_ack=1 SHALL clear pending[event_id], deassert event_valid, and go to GAP on that edge.
REQ-020 OFFER: a cycle counter SHALL start at 0 on entry; when it reaches ACK_TIMEOUT-1 with no ack, the block SHALL clear pending[event_id], deassert event_valid, pulse timeout_err for one cycle, and go to GAP. Ack in the final cycle SHALL take precedence and produce no timeout_err.
REQ-021 GAP: event_valid=0 for exactly one cycle, then go to IDLE.
REQ-022 event_ack while event_valid=0 SHALL be ignored.
REQ-023 Default arbitration: fixed priority, the lowest set index wins.
REQ-024 hit_pulse[id] in the same cycle as ack or timeout of event id SHALL leave pending[id]=1, so the event is re-offered, and SHALL NOT count as a drop.
REQ-025 startOfFrame SHALL clear drop_count to 0 and clear every pending bit except the one currently offered; hit_pulse bits in the same cycle SHALL still set pending, and their drops SHALL count from 0.
REQ-026 An offer in progress SHALL continue across startOfFrame unaffected.

Reset
REQ-027 resetN=1 SHALL force: state IDLE, event_valid=0, event_id=0, pending=0, drop_count=0, timeout_err=0, timeout counter=0, round-robin pointer=0.
REQ-028 resetN=1 during OFFER SHALL abort the offer with no timeout_err; reset has priority over all other inputs, including hit_pulse.

Configuration
REQ-029 Macro COLLISION_ARB_ROUND_ROBIN_EN defined: the winner SHALL be the first set pending bit searching upward from (last granted index + 1) modulo NUM_EVENTS; the pointer SHALL update on ack or timeout.
REQ-030 Macro undefined: fixed priority as in REQ-023, and no pointer register.

Verification
REQ-031 Single event: hit_pulse=7'b0000100 at cycle 10, ack held 1 -> event_valid=1 with event_id=2 at cycle 12, pending=0 at cycle 13, event_valid=0 at cycles 13-14.
REQ-032 Priority: hit_pulse=7'b1010010 with ack always 1 -> event_ids offered in order 1, 4, 6 (macro undefined); 1, 4, 6 from reset and order 4, 6, 1 when the pointer starts at 2 (macro defined).
REQ-033 Drop saturation: 300 hit_pulse[0] pulses with ack=0 and no startOfFrame -> drop_count stops at 255; then startOfFrame -> drop_count=0.
REQ-034 Timeout: hit_pulse[3], ack never asserted -> event_valid high for exactly 15 cycles, timeout_err pulses once, pending[3]=0.
REQ-035 Collision race: ack of id 5 in the same cycle as hit_pulse[5] -> pending[5] stays 1, drop_count unchanged, id 5 re-offered after GAP.
REQ-036 Reset mid-offer: resetN=1 during OFFER together with hit_pulse=7'h7F -> next cycle all outputs 0, and no event is offered afterwards.
